flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
Receiving end of the NZCV flag interface. Latches the 4-bit flag vector produced by the ALU flag decoder into the architectural flag register and evaluates ARM-style 4-bit condition codes for instructions at issue. Tracks in-flight flag-setting operations so a conditional instruction never reads stale flags. Sits between the issue stage (condition requests) and the ALU writeback (flag results).

Parameters:
PEND_W, 2, width of pending counter; max in-flight flag-setting ops PMAX = 2**PEND_W-1 (3)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
fin  input  4  flags from decoder, {Z,N,C,V} = fin[3:0]
fin_valid  input  1  fin carries a completing flag-setting result this cycle
msr_en  input  1  software flag write request
msr_flags  input  4  flag value for msr_en, same bit order
msr_ready  output  1  msr_en is accepted this cycle
cond  input  4  condition code of issuing instruction
cond_sets_flags  input  1  issuing instruction will later return fin_valid
cond_valid  input  1  issue request valid
cond_ready  output  1  issue accepted when cond_valid && cond_ready
pass  output  1  condition result of last accepted issue
pass_valid  output  1  pass is valid (1-cycle pulse)
flags  output  4  architectural flag register
pending  output  PEND_W  in-flight flag-setting op count
err  output  1  sticky: fin_valid seen with pending==0

Behaviour:
- Reset (async, any cycle, mid-operation included): flags=4'b0000, pending=0, pass=0, pass_valid=0, err=0; in-flight ops are dropped.
- Condition table (Z=fx[3],N=fx[2],C=fx[1],V=fx[0]): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- needs_flags = cond not in {14,15}.
- Bypass: eff = fin when fin_valid && pending==1, else flags.
- stall = needs_flags && (pending>1 || (pending==1 && !fin_valid)).
- full = cond_sets_flags && pending==PMAX && !fin_valid.
- cond_ready = !stall && !full (combinational; independent of cond_valid).
- Accept (cond_valid && cond_ready): next cycle pass_valid=1, pass=eval(cond,eff). Latency 1 cycle. Otherwise pass_valid=0, pass holds.
- Instruction that both reads and sets flags evaluates on eff (pre-own-result), then counts as pending.
- pending: +1 on accept with cond_sets_flags; -1 on fin_valid when pending>0; both same cycle -> unchanged. Never wraps.
- fin_valid with pending==0: flags still written, pending stays 0, err set (sticky until reset).
- flags update: fin_valid -> flags<=fin. msr_ready = (pending==0) && !fin_valid; msr_en && msr_ready -> flags<=msr_flags. msr_en when not ready: ignored, no state change; requester holds.
- fin_valid and accept same cycle: issue sees bypassed value only when pending==1; register update and evaluation are both from pre-edge values.

Decomposition:
- Shared package: COND_EQ..COND_NV localparams (4-bit), flag bit index constants Z_IDX=3,N_IDX=2,C_IDX=1,V_IDX=0, and eval function.
- One sub-module: cond_check (combinational, cond[3:0] + flags[3:0] -> pass), reusable by branch unit.

Test Plan:
- Reset then cond=EQ(0), valid, sets=0 -> ready=1, next cycle pass_valid=1, pass=0 (Z=0); cond=NE -> pass=1.
- Issue sets=1 (pending 0->1), then cond=GE valid with fin_valid=0 -> ready=0; next cycle fin=4'b0101 (N=1,V=1) fin_valid=1 -> ready=1, pass=1 via bypass, flags=4'b0101, pending=0.
- Three sets=1 issues with cond=AL -> pending=3; fourth sets=1 -> ready=0; same cycle fin_valid=1 -> accepted, pending stays 3.
- pending=1, msr_en=1, msr_flags=4'b1000 -> msr_ready=0, flags unchanged; after fin_valid (pending 0) msr accepted next cycle, flags=4'b1000, cond=LS -> pass=1.
- fin_valid=1 with pending=0, fin=4'b0010 -> flags=4'b0010, pending=0, err=1 and stays 1 until reset.
- Assert reset mid-stall with pending=2 -> flags=0, pending=0, pass_valid=0, err=0 immediately (async); first post-reset cond=GT accepted, pass=1.

Source files
------------

// File: rtl/flag_cond_unit_pkg.sv
// Shared definitions for the NZCV flag / condition-code logic.
// Provides the 4-bit condition-code encodings, the bit positions of the
// Z, N, C and V flags inside a 4-bit flag vector, and the evaluation
// function that maps (condition, flags) to a pass/fail result.
package flag_cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int Z_IDX = 3;
    localparam int N_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // Evaluate condition code c against flag vector f ({Z,N,C,V}).
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic z;
        logic n;
        logic cf;
        logic v;
        logic r;
        z  = f[Z_IDX];
        n  = f[N_IDX];
        cf = f[C_IDX];
        v  = f[V_IDX];
        case (c)
            COND_EQ: r = z;
            COND_NE: r = !z;
            COND_CS: r = cf;
            COND_CC: r = !cf;
            COND_MI: r = n;
            COND_PL: r = !n;
            COND_VS: r = v;
            COND_VC: r = !v;
            COND_HI: r = cf && !z;
            COND_LS: r = !cf || z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = !z && (n == v);
            COND_LE: r = z || (n != v);
            COND_AL: r = 1'b1;
            COND_NV: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flag_cond_unit_cond_check.sv
// Combinational condition-code checker, shared with the branch unit.
// Ports:
//   cond  [3:0] in  - condition code
//   flags [3:0] in  - flag vector {Z,N,C,V}
//   pass        out - 1 when the condition holds
module cond_check
    import flag_cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    // Pure table lookup through the shared evaluation function.
    always_comb begin
        pass = cond_eval(cond, flags);
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural NZCV flag register plus condition evaluation at issue.
// Counts in-flight flag-setting operations so that a flag-reading issue
// stalls until its flags are final, with a bypass of the completing result
// when exactly one producer is outstanding.
// Ports:
//   clk, reset            - clock (rising edge), async active-high reset
//   fin[3:0], fin_valid   - completing flag result from the ALU decoder
//   msr_en, msr_flags     - software flag write; msr_ready accepts it
//   cond, cond_sets_flags,
//   cond_valid/cond_ready - issue request handshake
//   pass, pass_valid      - registered condition result (1-cycle pulse)
//   flags                 - architectural flag register
//   pending               - outstanding flag-setting operations
//   err                   - sticky: completion arrived with nothing pending
module flag_cond_unit
    import flag_cond_unit_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        fin,
    input  logic              fin_valid,
    input  logic              msr_en,
    input  logic [3:0]        msr_flags,
    output logic              msr_ready,
    input  logic [3:0]        cond,
    input  logic              cond_sets_flags,
    input  logic              cond_valid,
    output logic              cond_ready,
    output logic              pass,
    output logic              pass_valid,
    output logic [3:0]        flags,
    output logic [PEND_W-1:0] pending,
    output logic              err
);

    localparam logic [PEND_W-1:0] P_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] P_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [PEND_W-1:0] P_MAX  = {PEND_W{1'b1}};

    logic [3:0]        flags_q, flags_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              pass_q, pass_d;
    logic              pass_valid_q, pass_valid_d;
    logic              err_q, err_d;

    logic [3:0]        eff_s;
    logic              needs_flags_s;
    logic              stall_s;
    logic              full_s;
    logic              cond_ready_s;
    logic              msr_ready_s;
    logic              accept_s;
    logic              inc_s;
    logic              dec_s;
    logic              eval_pass_s;

    cond_check u_cond_check (
        .cond  (cond),
        .flags (eff_s),
        .pass  (eval_pass_s)
    );

    // Issue-side hazard logic: bypass selection, stall/full and handshakes.
    always_comb begin
        // Only when the single outstanding producer completes this cycle is
        // its result the one the issuing instruction must see.
        if (fin_valid && (pending_q == P_ONE)) begin
            eff_s = fin;
        end else begin
            eff_s = flags_q;
        end
        needs_flags_s = (cond != COND_AL) && (cond != COND_NV);
        stall_s       = needs_flags_s &&
                        ((pending_q > P_ONE) || ((pending_q == P_ONE) && !fin_valid));
        // A completion in the same cycle frees a slot, so the counter cannot wrap.
        full_s        = cond_sets_flags && (pending_q == P_MAX) && !fin_valid;
        cond_ready_s  = !stall_s && !full_s;
        msr_ready_s   = (pending_q == P_ZERO) && !fin_valid;
        accept_s      = cond_valid && cond_ready_s;
        inc_s         = accept_s && cond_sets_flags;
        dec_s         = fin_valid && (pending_q != P_ZERO);
    end

    // Next-state computation for flags, pending count, result and error.
    always_comb begin
        flags_d      = flags_q;
        pending_d    = pending_q;
        pass_d       = pass_q;
        pass_valid_d = 1'b0;
        err_d        = err_q;

        if (fin_valid) begin
            flags_d = fin;
        end else if (msr_en && msr_ready_s) begin
            flags_d = msr_flags;
        end else begin
            flags_d = flags_q;
        end

        if (inc_s && !dec_s) begin
            pending_d = pending_q + P_ONE;
        end else if (dec_s && !inc_s) begin
            pending_d = pending_q - P_ONE;
        end else begin
            pending_d = pending_q;
        end

        if (accept_s) begin
            pass_d       = eval_pass_s;
            pass_valid_d = 1'b1;
        end else begin
            pass_d       = pass_q;
            pass_valid_d = 1'b0;
        end

        if (fin_valid && (pending_q == P_ZERO)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q      <= 4'b0000;
            pending_q    <= P_ZERO;
            pass_q       <= 1'b0;
            pass_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            pending_q    <= pending_d;
            pass_q       <= pass_d;
            pass_valid_q <= pass_valid_d;
            err_q        <= err_d;
        end
    end

    assign flags      = flags_q;
    assign pending    = pending_q;
    assign pass       = pass_q;
    assign pass_valid = pass_valid_q;
    assign err        = err_q;
    assign cond_ready = cond_ready_s;
    assign msr_ready  = msr_ready_s;

endmodule

// File: tb/tb_flag_cond_unit.sv
module tb_flag_cond_unit;

    logic       clk;
    logic       reset;
    logic [3:0] fin;
    logic       fin_valid;
    logic       msr_en;
    logic [3:0] msr_flags;
    logic       msr_ready;
    logic [3:0] cond;
    logic       cond_sets_flags;
    logic       cond_valid;
    logic       cond_ready;
    logic       pass;
    logic       pass_valid;
    logic [3:0] flags;
    logic [1:0] pending;
    logic       err;

    flag_cond_unit #(.PEND_W(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .fin             (fin),
        .fin_valid       (fin_valid),
        .msr_en          (msr_en),
        .msr_flags       (msr_flags),
        .msr_ready       (msr_ready),
        .cond            (cond),
        .cond_sets_flags (cond_sets_flags),
        .cond_valid      (cond_valid),
        .cond_ready      (cond_ready),
        .pass            (pass),
        .pass_valid      (pass_valid),
        .flags           (flags),
        .pending         (pending),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_pend;
    logic [3:0] m_flags;
    logic       m_pass;
    logic       m_pv;
    logic       m_err;
    logic       last_rdy;
    logic       last_mrdy;

    typedef struct {
        logic [3:0] c;
        logic [3:0] f;
        logic       exp;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Odd condition codes are the negation of the even code below them.
    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
        bit z, n, cf, v, base;
        int pair;
        z = f[3]; n = f[2]; cf = f[1]; v = f[0];
        pair = int'(c) / 2;
        if (pair == 0)      base = z;
        else if (pair == 1) base = cf;
        else if (pair == 2) base = n;
        else if (pair == 3) base = v;
        else if (pair == 4) base = cf & ~z;
        else if (pair == 5) base = (n == v);
        else if (pair == 6) base = ~z & (n == v);
        else                base = 1'b1;
        return base ^ c[0];
    endfunction

    task automatic cycle(input logic cv, input logic [3:0] c, input logic cs,
                         input logic fv, input logic [3:0] f,
                         input logic me, input logic [3:0] mf);
        logic [3:0] eff;
        logic needs, stall, full, rdy, mrdy, acc;
        cond_valid = cv; cond = c; cond_sets_flags = cs;
        fin_valid = fv; fin = f; msr_en = me; msr_flags = mf;
        #1;
        eff   = (fv && m_pend == 1) ? f : m_flags;
        needs = (c < 4'd14);
        stall = needs && (m_pend > 1 || (m_pend == 1 && !fv));
        full  = cs && m_pend == 3 && !fv;
        rdy   = !stall && !full;
        mrdy  = (m_pend == 0) && !fv;
        acc   = cv && rdy;
        last_rdy  = cond_ready;
        last_mrdy = msr_ready;
        chk("cond_ready", cond_ready, rdy);
        chk("msr_ready", msr_ready, mrdy);
        if (acc) begin
            m_pass = ref_eval(c, eff);
            m_pv   = 1'b1;
        end else begin
            m_pv   = 1'b0;
        end
        if (fv && m_pend == 0) m_err = 1'b1;
        m_pend = m_pend + ((acc && cs) ? 1 : 0) - ((fv && m_pend > 0) ? 1 : 0);
        if (fv)              m_flags = f;
        else if (me && mrdy) m_flags = mf;
        @(posedge clk);
        #1;
        chk("pass", pass, m_pass);
        chk("pass_valid", pass_valid, m_pv);
        chk("flags", flags, m_flags);
        chk("pending", pending, m_pend);
        chk("err", err, m_err);
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_flags", flags, 4'b0000);
        chk("rst_pending", pending, 2'd0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_pass_valid", pass_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        m_pend = 0; m_flags = 4'b0000; m_pass = 1'b0; m_pv = 1'b0; m_err = 1'b0;
        cond_valid = 1'b0; cond = 4'd0; cond_sets_flags = 1'b0;
        fin_valid = 1'b0; fin = 4'd0; msr_en = 1'b0; msr_flags = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cond_valid = 1'b0; cond = 4'd0; cond_sets_flags = 1'b0;
        fin_valid = 1'b0; fin = 4'd0; msr_en = 1'b0; msr_flags = 4'd0;
        tbl[0]  = '{4'd0,  4'b1000, 1'b1};
        tbl[1]  = '{4'd1,  4'b1000, 1'b0};
        tbl[2]  = '{4'd2,  4'b0010, 1'b1};
        tbl[3]  = '{4'd3,  4'b0010, 1'b0};
        tbl[4]  = '{4'd4,  4'b0100, 1'b1};
        tbl[5]  = '{4'd5,  4'b0000, 1'b1};
        tbl[6]  = '{4'd6,  4'b0000, 1'b0};
        tbl[7]  = '{4'd7,  4'b0000, 1'b1};
        tbl[8]  = '{4'd8,  4'b0010, 1'b1};
        tbl[9]  = '{4'd9,  4'b0010, 1'b0};
        tbl[10] = '{4'd10, 4'b0101, 1'b1};
        tbl[11] = '{4'd11, 4'b0100, 1'b1};
        tbl[12] = '{4'd12, 4'b1101, 1'b0};
        tbl[13] = '{4'd13, 4'b0001, 1'b1};
        tbl[14] = '{4'd14, 4'b0000, 1'b1};
        tbl[15] = '{4'd15, 4'b1111, 1'b0};
        #12;
        @(posedge clk);
        #1;
        do_reset();

        // Basic EQ / NE on reset flags
        cycle(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("eq_ready", last_rdy, 1'b1);
        chk("eq_pv", pass_valid, 1'b1);
        chk("eq_pass", pass, 1'b0);
        cycle(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("ne_pass", pass, 1'b1);
        idle();
        chk("hold_pv", pass_valid, 1'b0);
        chk("hold_pass", pass, 1'b1);

        // Stall on pending producer, then bypass
        cycle(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("p1", pending, 2'd1);
        cycle(1'b1, 4'd10, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("ge_stall", last_rdy, 1'b0);
        chk("ge_stall_pv", pass_valid, 1'b0);
        cycle(1'b1, 4'd10, 1'b0, 1'b1, 4'b0101, 1'b0, 4'd0);
        chk("ge_bypass_rdy", last_rdy, 1'b1);
        chk("ge_bypass_pass", pass, 1'b1);
        chk("ge_flags", flags, 4'b0101);
        chk("ge_pend", pending, 2'd0);

        // Pending saturation
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("p3", pending, 2'd3);
        cycle(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("full_rdy", last_rdy, 1'b0);
        chk("full_pend", pending, 2'd3);
        cycle(1'b1, 4'd14, 1'b1, 1'b1, 4'b0011, 1'b0, 4'd0);
        chk("full_fin_rdy", last_rdy, 1'b1);
        chk("full_fin_pend", pending, 2'd3);
        chk("full_fin_pv", pass_valid, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd0);
        chk("drained", pending, 2'd0);

        // MSR blocked by pending, then accepted
        cycle(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'b1000);
        chk("msr_blk", last_mrdy, 1'b0);
        chk("msr_blk_flags", flags, 4'b0000);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b1000);
        chk("msr_blk_fin", last_mrdy, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'b1000);
        chk("msr_ok", last_mrdy, 1'b1);
        chk("msr_flags", flags, 4'b1000);
        cycle(1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("ls_pass", pass, 1'b1);

        // Orphan completion sets sticky error
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'b0010, 1'b0, 4'd0);
        chk("orph_flags", flags, 4'b0010);
        chk("orph_pend", pending, 2'd0);
        chk("orph_err", err, 1'b1);
        idle(); idle();
        chk("err_sticky", err, 1'b1);
        do_reset();

        // Full condition table
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, tbl[i].f);
            cycle(1'b1, tbl[i].c, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
            chk("tbl_pass", pass, tbl[i].exp);
        end

        // Reset in the middle of a stall
        do_reset();
        cycle(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        cycle(1'b1, 4'd14, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("p2", pending, 2'd2);
        cycle(1'b1, 4'd10, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("p2_stall", last_rdy, 1'b0);
        cond_valid = 1'b1; cond = 4'd10;
        do_reset();
        cycle(1'b1, 4'd12, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("gt_rdy", last_rdy, 1'b1);
        chk("gt_pass", pass, 1'b1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic fv;
            if (m_pend > 0) fv = ($urandom_range(2) == 0);
            else            fv = ($urandom_range(40) == 0);
            cycle(($urandom_range(3) != 0), 4'($urandom_range(15)), 1'($urandom_range(1)),
                  fv, 4'($urandom_range(15)),
                  ($urandom_range(3) == 0), 4'($urandom_range(15)));
            if (i % 700 == 699) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
